// File: rtl/bwn_pkg.sv
// Shared Q-format constants, FSM state type and the Q(IW,4) -> Q(WL,4) saturator
// for the BWN conv/pool pipeline.
package bwn_pkg;
   localparam int FRAC = 4;
   localparam int WL   = 8;
   localparam int IW   = WL + 8;

   typedef enum logic [1:0] {IDLE, WAIT, RUN, DONE} state_t;

   // Both formats carry FRAC fractional bits, so only the integer range is clipped.
   function automatic logic signed [WL-1:0] sat_q(input logic signed [IW-1:0] x);
      localparam logic signed [IW-1:0] SAT_HI = IW'((1 << (WL-1)) - 1);
      localparam logic signed [IW-1:0] SAT_LO = ~SAT_HI;
      if (x > SAT_HI)
         return SAT_HI[WL-1:0];
      else if (x < SAT_LO)
         return SAT_LO[WL-1:0];
      else
         return x[WL-1:0];
   endfunction
endpackage

// File: rtl/conv_pool_requant_row_buf.sv
// Row buffer for the 2x2 max-pool: holds the horizontal maxima of the even
// window row. Synchronous write, asynchronous read, one shared address.
module pool_row_buf #(
   parameter int DEPTH = 8,
   parameter int WL    = 8,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [AW-1:0]        addr,
   input  logic signed [WL-1:0] wdata,
   output logic signed [WL-1:0] rdata
);
   logic signed [WL-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we)
         mem[addr] <= wdata;
   end

   assign rdata = mem[addr];
endmodule

// File: rtl/conv_pool_requant.sv
// Border rejection, Q(16,4)->Q(8,4) saturation and 2x2/2 max-pool after the BWN conv.
// Optional macro POOL_RELU_EN rectifies each saturated sample before pooling.
module conv_pool_requant
   import bwn_pkg::*;
#(
   parameter int WL    = bwn_pkg::WL,
   parameter int IW    = bwn_pkg::IW,
   parameter int IMG_W = 18,
   parameter int IMG_H = 18,
   parameter int LAT   = 1
) (
   input  logic                 iCLK,
   input  logic                 iRST,
   input  logic                 iSTART,
   input  logic signed [IW-1:0] iDATA,
   output logic signed [WL-1:0] oDATA,
   output logic                 oVALID,
   output logic                 oDONE
);
   localparam int CW  = IMG_W - 2;
   localparam int CH  = IMG_H - 2;
   localparam int PW  = CW / 2;
   localparam int CLW = $clog2(IMG_W);
   localparam int RWW = $clog2(IMG_H);
   localparam int LW  = (LAT > 0) ? $clog2(LAT + 1) : 1;
   localparam int AW  = (PW > 1) ? $clog2(PW) : 1;

   state_t               state;
   logic [CLW-1:0]       col, vc;
   logic [RWW-1:0]       row, vr;
   logic [LW-1:0]        lat_cnt;
   logic                 start_q;
   logic                 in_win, we, pool_out;
   logic [AW-1:0]        addr;
   logic signed [WL-1:0] sat_v, s, hreg, h, rd, bmax;

   always_comb begin
      sat_v = sat_q(iDATA);
`ifdef POOL_RELU_EN
      s = (sat_v < 0) ? '0 : sat_v;
`else
      s = sat_v;
`endif
      vc = col - CLW'(2);
      vr = row - RWW'(2);
      // Trailing odd column/row of the conv map never completes a block, so it is excluded here.
      in_win = (state == RUN) && iSTART && (col >= CLW'(2)) && (row >= RWW'(2))
               && (vc < CLW'(2*PW)) && (vr < RWW'(2*(CH/2)));
      h        = (hreg > s) ? hreg : s;
      addr     = AW'(vc >> 1);
      we       = in_win && vc[0] && !vr[0];
      pool_out = in_win && vc[0] && vr[0];
      bmax     = (rd > h) ? rd : h;
   end

   pool_row_buf #(.DEPTH(PW), .WL(WL), .AW(AW)) u_row_buf (
      .clk   (iCLK),
      .we    (we),
      .addr  (addr),
      .wdata (h),
      .rdata (rd)
   );

   always_ff @(posedge iCLK) begin
      if (in_win && !vc[0])
         hreg <= s;
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state   <= IDLE;
         col     <= '0;
         row     <= '0;
         lat_cnt <= '0;
         start_q <= 1'b0;
         oDATA   <= '0;
         oVALID  <= 1'b0;
         oDONE   <= 1'b0;
      end else begin
         start_q <= iSTART;
         oVALID  <= 1'b0;
         oDONE   <= 1'b0;
         case (state)
            IDLE: begin
               // Rising edge only: a start held high through DONE must not retrigger.
               if (iSTART && !start_q) begin
                  state   <= WAIT;
                  lat_cnt <= LW'(LAT);
               end
            end
            WAIT: begin
               if (!iSTART) begin
                  state   <= IDLE;
                  lat_cnt <= '0;
               end else if (lat_cnt == '0) begin
                  state <= RUN;
                  col   <= '0;
                  row   <= '0;
               end else begin
                  lat_cnt <= lat_cnt - LW'(1);
               end
            end
            RUN: begin
               if (!iSTART) begin
                  state <= IDLE;
                  col   <= '0;
                  row   <= '0;
               end else begin
                  if (pool_out) begin
                     oDATA  <= bmax;
                     oVALID <= 1'b1;
                  end
                  if (col == CLW'(IMG_W - 1)) begin
                     col <= '0;
                     if (row == RWW'(IMG_H - 1)) begin
                        row   <= '0;
                        state <= DONE;
                     end else begin
                        row <= row + RWW'(1);
                     end
                  end else begin
                     col <= col + CLW'(1);
                  end
               end
            end
            DONE: begin
               oDONE <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_conv_pool_requant.sv
// Scoreboard bench for conv_pool_requant on a 6x6 raster (4x4 conv map, 2x2 pooled map).
module tb_conv_pool_requant;
   localparam int W = 6;
   localparam int H = 6;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic signed [15:0] din;
   logic signed [7:0]  dout;
   logic               vld;
   logic               done;

   typedef struct {
      int val;
      int cyc;
   } exp_t;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   nvalid;
   int   last_exp;
   int   pix [W*H];
   exp_t q [$];
   exp_t e_m;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   conv_pool_requant #(.IMG_W(W), .IMG_H(H), .LAT(1)) dut (
      .iCLK   (clk),
      .iRST   (rst),
      .iSTART (start),
      .iDATA  (din),
      .oDATA  (dout),
      .oVALID (vld),
      .oDONE  (done)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   function automatic int satm(input int x);
      int y;
      y = (x > 127) ? 127 : ((x < -128) ? -128 : x);
`ifdef POOL_RELU_EN
      if (y < 0) y = 0;
`endif
      return y;
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Output monitor: every oVALID pops one expectation and must land on its cycle.
   always @(negedge clk) begin
      if (vld === 1'b1) begin
         nvalid++;
         if (q.size() == 0) begin
            chk("spurious_valid", 1, 0);
         end else begin
            e_m = q.pop_front();
            chk("pool_data", int'(dout), e_m.val);
            chk("valid_cycle", cyc, e_m.cyc);
         end
      end
   end

   task automatic push_exp(input int k);
      int r, c, v;
      r = k / W;
      c = k % W;
      if (r >= 3 && c >= 3 && ((r - 2) % 2) == 1 && ((c - 2) % 2) == 1) begin
         v = max2(max2(satm(pix[(r-1)*W + c-1]), satm(pix[(r-1)*W + c])),
                  max2(satm(pix[r*W + c-1]), satm(pix[k])));
         q.push_back('{val: v, cyc: cyc + 1});
         last_exp = v;
      end
   endtask

   task automatic fill(input int mode);
      int r, c, vr, vc, b, i;
      for (int k = 0; k < W*H; k++) begin
         r = k / W;
         c = k % W;
         if (r < 2 || c < 2) begin
            pix[k] = (mode == 3) ? 127 : 0;
         end else begin
            vr = r - 2;
            vc = c - 2;
            b  = (vr / 2) * 2 + vc / 2;
            i  = (vr % 2) * 2 + vc % 2;
            case (mode)
               0: pix[k] = (vr * 4 + vc) * 16;
               1: case (b)
                     0: pix[k] = (i == 2) ? 3000 : 20;
                     1: pix[k] = 3000;
                     2: pix[k] = (i == 0) ? -3000 : 33;
                     default: pix[k] = -3000;
                  endcase
               2: if (b == 0) begin
                     case (i)
                        0: pix[k] = -5;
                        1: pix[k] = -9;
                        2: pix[k] = -2;
                        default: pix[k] = -7;
                     endcase
                  end else begin
                     pix[k] = int'($urandom_range(200)) - 100;
                  end
               3: pix[k] = -1 - int'($urandom_range(49));
               default: pix[k] = int'($urandom_range(8000)) - 4000;
            endcase
         end
      end
   endtask

   task automatic run_frame(input int abort_at, input int rst_at);
      nvalid = 0;
      @(negedge clk);
      start = 1'b1;
      din   = '0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < W*H; k++) begin
         din = 16'(pix[k]);
         if (k == abort_at) start = 1'b0;
         if (k == rst_at) rst = 1'b1;
         if (k == abort_at || k == rst_at) begin
            @(negedge clk);
            chk("stop_valid", vld, 0);
            chk("stop_done", done, 0);
            if (k == rst_at) chk("rst_data", int'(dout), 0);
            rst   = 1'b0;
            start = 1'b0;
            repeat (4) begin
               @(negedge clk);
               chk("idle_done", done, 0);
            end
            return;
         end
         push_exp(k);
         @(negedge clk);
      end
      @(negedge clk);
      chk("done_pulse", done, 1);
      chk("done_valid_low", vld, 0);
      chk("hold_data", int'(dout), last_exp);
      start = 1'b0;
      @(negedge clk);
      chk("done_single", done, 0);
      chk("n_outputs", nvalid, 4);
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      din   = '0;
      repeat (3) @(negedge clk);
      chk("rst_data", int'(dout), 0);
      chk("rst_valid", vld, 0);
      chk("rst_done", done, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_valid", vld, 0);

      fill(0); run_frame(-1, -1);
      fill(1); run_frame(-1, -1);
      fill(2); run_frame(-1, -1);
      fill(3); run_frame(-1, -1);
      fill(4); run_frame(-1, -1);
      fill(0); run_frame(20, -1);
      run_frame(-1, -1);
      run_frame(-1, 22);
      fill(4); run_frame(-1, -1);

      repeat (3) @(negedge clk);
      chk("queue_empty", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
